ikun_bbox_detect: RTL and testbench

Motion bounding-box extractor placed directly downstream of the 3x3 erosion stage in the frame-difference tracking chain. Consumes the 1-bit eroded foreground mask as an AXI4-Stream video stream and forwards it unchanged, registered one stage, to the next consumer. In parallel it accumulates the min/max column and row of all foreground pixels in each frame. At frame end it publishes one bounding box for the overlay/tracker logic.

---
 rtl/ikun_bbox_detect_if.sv | 11 +
 rtl/ikun_bbox_detect.sv | 196 +++++++++++++++++++
 tb/tb_ikun_bbox_detect.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/ikun_bbox_detect_if.sv
// 1-bit AXI4-Stream video link carrying the eroded foreground mask.
interface ikun_bbox_detect_if;
    logic tdata;
    logic tvalid;
    logic tready;
    logic tlast;
    logic tuser;

    modport master (output tdata, tvalid, tlast, tuser, input tready);
    modport slave  (input tdata, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/ikun_bbox_detect.sv
// Motion bounding-box extractor: registers the mask stream one stage and publishes
// per-frame min/max foreground coordinates. Optional IKUN_BBOX_MIN_AREA_EN adds a pixel-count qualifier.
module ikun_bbox_detect #(
    parameter int AW       = 11,
    parameter int COLS     = 1280,
    parameter int ROWS     = 720,
    parameter int CW       = 21,
    parameter int MIN_AREA = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    ikun_bbox_detect_if.slave    s_axis_video,
    ikun_bbox_detect_if.master   m_axis_video,
    output logic [AW-1:0]        box_xmin,
    output logic [AW-1:0]        box_xmax,
    output logic [AW-1:0]        box_ymin,
    output logic [AW-1:0]        box_ymax,
    output logic                 box_found,
    output logic                 box_valid
);

    localparam logic [AW-1:0] XLAST = AW'(COLS - 1);
    localparam logic [AW-1:0] YLAST = AW'(ROWS - 1);

    logic          m_tdata_q, m_tvalid_q, m_tlast_q, m_tuser_q;
    logic [AW-1:0] x_q, x_d, y_q, y_d;
    logic [AW-1:0] xmin_q, xmin_d, xmax_q, xmax_d, ymin_q, ymin_d, ymax_q, ymax_d;
    logic          seen_q, seen_d;
    logic [AW-1:0] bxmin_q, bxmin_d, bxmax_q, bxmax_d, bymin_q, bymin_d, bymax_q, bymax_d;
    logic          bfound_q, bfound_d, bvld_q, bvld_d;

    logic          acc, sof, fg, eof, seen_b, seen_n, qual;
    logic [AW-1:0] px, py;
    logic [AW-1:0] xmin_b, xmax_b, ymin_b, ymax_b;
    logic [AW-1:0] xmin_n, xmax_n, ymin_n, ymax_n;

`ifdef IKUN_BBOX_MIN_AREA_EN
    logic [CW-1:0] cnt_q, cnt_d, cnt_b, cnt_n;
`endif

    assign s_axis_video.tready = m_axis_video.tready;

    always_comb begin
        acc = s_axis_video.tvalid && m_axis_video.tready;
        sof = acc && s_axis_video.tuser;
        fg  = acc && s_axis_video.tdata;
        // A tuser beat is pixel (0,0) of a fresh frame, regardless of counter state.
        px  = sof ? '0 : x_q;
        py  = sof ? '0 : y_q;
        eof = acc && s_axis_video.tlast && (py == YLAST);

        seen_b = sof ? 1'b0 : seen_q;
        xmin_b = sof ? '0 : xmin_q;
        xmax_b = sof ? '0 : xmax_q;
        ymin_b = sof ? '0 : ymin_q;
        ymax_b = sof ? '0 : ymax_q;

        xmin_n = xmin_b;
        xmax_n = xmax_b;
        ymin_n = ymin_b;
        ymax_n = ymax_b;
        if (fg) begin
            if (!seen_b) begin
                xmin_n = px;
                xmax_n = px;
                ymin_n = py;
                ymax_n = py;
            end else begin
                if (px < xmin_b) xmin_n = px;
                if (px > xmax_b) xmax_n = px;
                if (py < ymin_b) ymin_n = py;
                if (py > ymax_b) ymax_n = py;
            end
        end
        seen_n = seen_b | fg;

`ifdef IKUN_BBOX_MIN_AREA_EN
        cnt_b = sof ? '0 : cnt_q;
        cnt_n = (fg && (cnt_b != '1)) ? cnt_b + 1'b1 : cnt_b;
        qual  = seen_n && (cnt_n >= CW'(MIN_AREA));
`else
        qual  = seen_n;
`endif
    end

    always_comb begin
        x_d      = x_q;
        y_d      = y_q;
        xmin_d   = xmin_n;
        xmax_d   = xmax_n;
        ymin_d   = ymin_n;
        ymax_d   = ymax_n;
        seen_d   = seen_n;
        bxmin_d  = bxmin_q;
        bxmax_d  = bxmax_q;
        bymin_d  = bymin_q;
        bymax_d  = bymax_q;
        bfound_d = bfound_q;
        bvld_d   = 1'b0;
`ifdef IKUN_BBOX_MIN_AREA_EN
        cnt_d    = cnt_n;
`endif
        if (acc) begin
            if (s_axis_video.tlast) begin
                x_d = '0;
                y_d = py + 1'b1;
            end else begin
                x_d = (px == XLAST) ? px : px + 1'b1;
                y_d = py;
            end
        end
        if (eof) begin
            y_d      = '0;
            bxmin_d  = qual ? xmin_n : '0;
            bxmax_d  = qual ? xmax_n : '0;
            bymin_d  = qual ? ymin_n : '0;
            bymax_d  = qual ? ymax_n : '0;
            bfound_d = qual;
            bvld_d   = 1'b1;
            xmin_d   = '0;
            xmax_d   = '0;
            ymin_d   = '0;
            ymax_d   = '0;
            seen_d   = 1'b0;
`ifdef IKUN_BBOX_MIN_AREA_EN
            cnt_d    = '0;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_tdata_q  <= 1'b0;
            m_tvalid_q <= 1'b0;
            m_tlast_q  <= 1'b0;
            m_tuser_q  <= 1'b0;
        end else if (m_axis_video.tready) begin
            m_tdata_q  <= s_axis_video.tdata;
            m_tvalid_q <= s_axis_video.tvalid;
            m_tlast_q  <= s_axis_video.tlast;
            m_tuser_q  <= s_axis_video.tuser;
        end
    end

    // Everything below only moves on accepted beats, so holding under stall falls out of _d.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q      <= '0;
            y_q      <= '0;
            xmin_q   <= '0;
            xmax_q   <= '0;
            ymin_q   <= '0;
            ymax_q   <= '0;
            seen_q   <= 1'b0;
            bxmin_q  <= '0;
            bxmax_q  <= '0;
            bymin_q  <= '0;
            bymax_q  <= '0;
            bfound_q <= 1'b0;
            bvld_q   <= 1'b0;
        end else begin
            x_q      <= x_d;
            y_q      <= y_d;
            xmin_q   <= xmin_d;
            xmax_q   <= xmax_d;
            ymin_q   <= ymin_d;
            ymax_q   <= ymax_d;
            seen_q   <= seen_d;
            bxmin_q  <= bxmin_d;
            bxmax_q  <= bxmax_d;
            bymin_q  <= bymin_d;
            bymax_q  <= bymax_d;
            bfound_q <= bfound_d;
            bvld_q   <= bvld_d;
        end
    end

`ifdef IKUN_BBOX_MIN_AREA_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
`endif

    assign m_axis_video.tdata  = m_tdata_q;
    assign m_axis_video.tvalid = m_tvalid_q;
    assign m_axis_video.tlast  = m_tlast_q;
    assign m_axis_video.tuser  = m_tuser_q;
    assign box_xmin  = bxmin_q;
    assign box_xmax  = bxmax_q;
    assign box_ymin  = bymin_q;
    assign box_ymax  = bymax_q;
    assign box_found = bfound_q;
    assign box_valid = bvld_q;

endmodule

// File: tb/tb_ikun_bbox_detect.sv
// Scoreboard bench for ikun_bbox_detect: bitmap frames in, expected boxes and beats queued, compared on output.
module tb_ikun_bbox_detect;
    localparam int AW = 4, COLS = 8, ROWS = 4, CW = 5, MIN_AREA = 3;
    localparam int NPIX = COLS * ROWS;

    typedef struct packed {
        logic          found;
        logic [AW-1:0] xmin, xmax, ymin, ymax;
    } box_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [AW-1:0] box_xmin, box_xmax, box_ymin, box_ymax;
    logic box_found, box_valid;

    ikun_bbox_detect_if s_if ();
    ikun_bbox_detect_if m_if ();

    ikun_bbox_detect #(.AW(AW), .COLS(COLS), .ROWS(ROWS), .CW(CW), .MIN_AREA(MIN_AREA)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_axis_video(s_if.slave), .m_axis_video(m_if.master),
        .box_xmin(box_xmin), .box_xmax(box_xmax), .box_ymin(box_ymin), .box_ymax(box_ymax),
        .box_found(box_found), .box_valid(box_valid)
    );

    always #5 clk = ~clk;

    int   n_chk = 0, n_fail = 0;
    box_t box_q[$];
    logic [2:0] vid_q[$];
    bit   rdy_toggle = 1'b0;
    int   ncyc = 0;
    time  eof_t = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Downstream ready: stalls one cycle in three when toggling is enabled.
    always @(negedge clk) begin
        ncyc++;
        m_if.tready = rdy_toggle ? ((ncyc % 3) != 0) : 1'b1;
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (m_if.tvalid && m_if.tready) begin
                if (vid_q.size() == 0) chk("vid_extra_beat", 1, 0);
                else chk("vid_beat", {m_if.tuser, m_if.tlast, m_if.tdata}, vid_q.pop_front());
            end
            if (box_valid) begin
                chk("box_latency", $time - eof_t, 5);
                if (box_q.size() == 0) chk("box_unexpected", 1, 0);
                else begin
                    box_t e;
                    e = box_q.pop_front();
                    chk("box_found", box_found, e.found);
                    chk("box_xmin", box_xmin, e.xmin);
                    chk("box_xmax", box_xmax, e.xmax);
                    chk("box_ymin", box_ymin, e.ymin);
                    chk("box_ymax", box_ymax, e.ymax);
                end
            end
        end
    end

    function automatic box_t model_box(input logic [NPIX-1:0] bm);
        box_t b;
        int cnt, x0, x1, y0, y1;
        bit ok;
        cnt = 0; x0 = COLS; x1 = -1; y0 = ROWS; y1 = -1;
        for (int y = 0; y < ROWS; y++)
            for (int x = 0; x < COLS; x++)
                if (bm[y*COLS + x]) begin
                    cnt++;
                    if (x < x0) x0 = x;
                    if (x > x1) x1 = x;
                    if (y < y0) y0 = y;
                    if (y > y1) y1 = y;
                end
`ifdef IKUN_BBOX_MIN_AREA_EN
        ok = (cnt >= MIN_AREA);
`else
        ok = (cnt > 0);
`endif
        b = '0;
        if (ok) begin
            b.found = 1'b1;
            b.xmin = AW'(x0); b.xmax = AW'(x1); b.ymin = AW'(y0); b.ymax = AW'(y1);
        end
        return b;
    endfunction

    task automatic send_beat(input logic d, input logic last, input logic user, input bit gaps, input bit is_eof);
        if (gaps && ($urandom_range(0, 3) == 0)) begin
            @(negedge clk);
            s_if.tvalid = 1'b0;
            @(posedge clk);
        end
        @(negedge clk);
        s_if.tvalid = 1'b1; s_if.tdata = d; s_if.tlast = last; s_if.tuser = user;
        for (int w = 0; w <= 40; w++) begin
            @(posedge clk);
            if (m_if.tready) break;
            if (w == 40) chk("accept_timeout", 1, 0);
        end
        vid_q.push_back({user, last, d});
        if (is_eof) eof_t = $time;
    endtask

    task automatic send_frame(input logic [NPIX-1:0] bm, input int nlines, input bit gaps);
        if (nlines == ROWS) box_q.push_back(model_box(bm));
        for (int y = 0; y < nlines; y++)
            for (int x = 0; x < COLS; x++)
                send_beat(bm[y*COLS + x], x == COLS-1, (x == 0) && (y == 0), gaps,
                          (x == COLS-1) && (y == ROWS-1));
        @(negedge clk);
        s_if.tvalid = 1'b0; s_if.tdata = 1'b0; s_if.tlast = 1'b0; s_if.tuser = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_mvalid"}, m_if.tvalid, 0);
        chk({tag, "_bvalid"}, box_valid, 0);
        chk({tag, "_bfound"}, box_found, 0);
        chk({tag, "_bcoords"}, {box_xmin, box_xmax, box_ymin, box_ymax}, 0);
    endtask

    function automatic logic [NPIX-1:0] px(input int x, input int y);
        logic [NPIX-1:0] b;
        b = '0;
        b[y*COLS + x] = 1'b1;
        return b;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NPIX-1:0] f_main;
        s_if.tvalid = 1'b0; s_if.tdata = 1'b0; s_if.tlast = 1'b0; s_if.tuser = 1'b0;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst_n = 1'b1;

        // Partial frame interrupted by reset, then a clean frame.
        send_frame(px(5, 0) | px(1, 1), 2, 1'b0);
        @(negedge clk);
        s_if.tvalid = 1'b1;
        #2 rst_n = 1'b0;
        #1 check_idle_outputs("midreset");
        s_if.tvalid = 1'b0;
        vid_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        send_frame(px(2, 1), ROWS, 1'b0);

        f_main = px(1, 0) | px(6, 2) | px(3, 3);
        send_frame(f_main, ROWS, 1'b0);
        send_frame('0, ROWS, 1'b0);

        rdy_toggle = 1'b1;
        send_frame(f_main, ROWS, 1'b1);
        rdy_toggle = 1'b0;

        // tuser re-asserted mid-frame discards the partial frame.
        send_frame(px(7, 0), 2, 1'b0);
        send_frame(px(0, 3), ROWS, 1'b0);

        // Area qualifier boundary: 2 then 3 foreground pixels.
        send_frame(px(4, 1) | px(5, 2), ROWS, 1'b0);
        send_frame(px(4, 1) | px(5, 2) | px(0, 0), ROWS, 1'b0);
        // Corner pixels at both extremes.
        send_frame(px(0, 0) | px(COLS-1, ROWS-1), ROWS, 1'b1);

        repeat (20) @(negedge clk);
        chk("box_q_drained", box_q.size(), 0);
        chk("vid_q_drained", vid_q.size(), 0);
        chk("held_bvalid", box_valid, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
